// File: rtl/dmem_responder_if.sv
// CPU data-memory handshake bundle between a data-path master and dmem_responder.
// Signal names keep the responder-side _i/_o suffixes so both ends read the same.
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  busy_o, ack_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output busy_o, ack_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory responder: IDLE -> WAIT -> RESP, one access in flight.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on err_o and suppress their effects.
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_d;
  logic             misaligned_d;

  logic [31:0]      mem [DEPTH];

  always_comb begin
    // NOTE: every _d starts from its held value so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i;
          busy_d  = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
            ack_d   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Response data is captured on the edge entering RESP, from the latched request.
    idx_d = addr_d[IDX_W+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned_d = (addr_d[1:0] != 2'b00);
`else
    misaligned_d = 1'b0;
`endif
    if (ack_d) begin
      err_d   = misaligned_d;
      rdata_d = (we_d || misaligned_d) ? 32'd0 : mem[idx_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: storage is deliberately not reset; contents survive rst_i, only an in-flight write is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == RESP && we_q && !err_q) begin
      mem[addr_q[IDX_W+1:2]] <= wdata_q;
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.ack_o   = ack_q;
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;

endmodule
